// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage.
// Holds the FSM state encoding and default widths.
// Imported by the interface, the queue and the fetch stage top.
package fetch_pkg;

  // Fetch FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  localparam int ADDR_W_DEF  = 64;
  localparam int INSTR_W_DEF = 32;

endpackage

// File: rtl/fetch_if.sv
// Bundles the control, I-cache and decode-side signals of the fetch stage.
// master: the fetch stage side; slave: the environment (cache + decode).
// Purely structural; no logic.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);
  logic               start_flag;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_addr;
  logic               icache_req_valid;
  logic               icache_req_ready;
  logic [ADDR_W-1:0]  icache_req_addr;
  logic               icache_resp_valid;
  logic [INSTR_W-1:0] icache_resp_data;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               out_ack;

  modport master (
    input  start_flag, redirect_valid, redirect_addr,
    input  icache_req_ready, icache_resp_valid, icache_resp_data, out_ack,
    output icache_req_valid, icache_req_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    output start_flag, redirect_valid, redirect_addr,
    output icache_req_ready, icache_resp_valid, icache_resp_data, out_ack,
    input  icache_req_valid, icache_req_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO holding fetched {pc, instr} entries for decode.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: full_o reported to the producer; flush beats push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = ADDR_W_DEF + INSTR_W_DEF,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o && !flush_i;
  assign do_pop     = pop_i && !empty_o && !flush_i;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointer and occupancy bookkeeping; flush empties the queue at once.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Sequential-PC instruction fetch with one outstanding I-cache read and a queue to decode.
// Latency: start -> request next cycle; response -> out_valid next cycle, next request too.
// Backpressure: no request while the queue is full; decode pops with out_ack.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               ADDR_W      = ADDR_W_DEF,
  parameter int               INSTR_W     = INSTR_W_DEF,
  parameter int               FETCH_BYTES = 4,
  parameter int               QDEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.master fb
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(FETCH_BYTES) - ADDR_W'(1));

  fetch_state_e               state_q, state_d;
  logic [ADDR_W-1:0]          pc_q, pc_d;
  logic                       q_push, q_pop, q_flush, q_full, q_empty;
  logic [CW-1:0]              q_count;
  logic [ADDR_W+INSTR_W-1:0]  q_head;
  logic                       redirect, req_hs;

  // A redirect only flushes and counts once fetching has started.
  assign redirect = fb.redirect_valid && (state_q != IDLE);
  assign fb.icache_req_valid = (state_q == REQ) && (q_count < CW'(QDEPTH));
  assign fb.icache_req_addr  = (state_q == REQ) ? pc_q : '0;
  assign req_hs  = fb.icache_req_valid && fb.icache_req_ready;
  assign q_flush = redirect;
  assign q_pop   = !q_empty && fb.out_ack && !redirect;

  assign fb.out_valid = !q_empty;
  assign fb.out_pc    = q_empty ? '0 : q_head[ADDR_W+INSTR_W-1 -: ADDR_W];
  assign fb.out_instr = q_empty ? '0 : q_head[INSTR_W-1:0];

  // Next-state, PC update and push decision; redirect overrides the normal flow.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    q_push  = 1'b0;
    case (state_q)
      IDLE:    if (fb.start_flag) state_d = REQ;
      REQ:     if (req_hs) state_d = WAIT;
      WAIT: begin
        if (fb.icache_resp_valid) begin
          q_push  = !q_full;
          pc_d    = pc_q + ADDR_W'(FETCH_BYTES);
          state_d = REQ;
        end
      end
      DISCARD: if (fb.icache_resp_valid) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (fb.redirect_valid) begin
      pc_d = fb.redirect_addr & ALIGN_MASK;
      if (state_q != IDLE) begin
        q_push = 1'b0;
        case (state_q)
          REQ:     state_d = req_hs ? DISCARD : REQ;
          WAIT:    state_d = fb.icache_resp_valid ? REQ : DISCARD;
          DISCARD: state_d = fb.icache_resp_valid ? REQ : DISCARD;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(
    .WIDTH (ADDR_W + INSTR_W),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push_i     (q_push),
    .pop_i      (q_pop),
    .flush_i    (q_flush),
    .push_dat_i ({pc_q, fb.icache_resp_data}),
    .head_dat_o (q_head),
    .full_o     (q_full),
    .empty_o    (q_empty),
    .count_o    (q_count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (q_push)   fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 2-cycle-latency I-cache model.
// Inputs change at negedge+1; the cache model updates at negedge and negedge+2.
// Expected addresses and data are hand-computed constants.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif

  fetch_stage #(
    .ADDR_W      (64),
    .INSTR_W     (32),
    .FETCH_BYTES (4),
    .QDEPTH      (4),
    .RESET_PC    (64'h1000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fb    (bus.master)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // I-cache model: response 2 cycles after handshake, data = addr[31:0] ^ 0xDEAD0000
  int unsigned cache_cnt = 0;
  logic [63:0] cache_addr = '0;
  int unsigned hs_count = 0;
  logic [63:0] hs_log[$];

  always @(negedge clk) begin
    bus.icache_resp_valid = 1'b0;
    if (cache_cnt != 0) begin
      cache_cnt = cache_cnt - 1;
      if (cache_cnt == 0) begin
        bus.icache_resp_valid = 1'b1;
        bus.icache_resp_data  = cache_addr[31:0] ^ 32'hDEAD0000;
      end
    end
    #2;
    if (bus.icache_req_valid === 1'b1 && bus.icache_req_ready === 1'b1) begin
      cache_cnt  = 2;
      cache_addr = bus.icache_req_addr;
      hs_count   = hs_count + 1;
      hs_log.push_back(bus.icache_req_addr);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start_flag = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = '0;
    bus.icache_req_ready = 1'b1;
    bus.out_ack = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.icache_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", bus.icache_req_valid); end
    checks++;
    if (bus.icache_req_addr !== 64'h0) begin errors++; $display("FAIL reset_req_addr: got %h expected 0", bus.icache_req_addr); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.out_pc !== 64'h0 || bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_data: got pc %h instr %h expected 0 0", bus.out_pc, bus.out_instr); end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_fetch_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin errors++; $display("FAIL reset_perf: got %0d %0d expected 0 0", perf_fetch_cnt, perf_flush_cnt); end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_start_latency();
    bit ok;
    bus.start_flag = 1'b1;
    tick();
    bus.start_flag = 1'b0;
    checks++;
    if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 64'h1000) begin errors++; $display("FAIL start_req: got v=%b addr=%h expected v=1 addr=1000", bus.icache_req_valid, bus.icache_req_addr); end
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (bus.icache_resp_valid === 1'b1) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL start_resp_wait: got timeout expected response"); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h1000 || bus.out_instr !== 32'hDEAD1000) begin errors++; $display("FAIL first_out: got v=%b pc=%h instr=%h expected v=1 pc=1000 instr=dead1000", bus.out_valid, bus.out_pc, bus.out_instr); end
    checks++;
    if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 64'h1004) begin errors++; $display("FAIL second_req: got v=%b addr=%h expected v=1 addr=1004", bus.icache_req_valid, bus.icache_req_addr); end
  endtask

  task automatic test_fill_and_ack();
    bit ok;
    logic [63:0] exp_pc;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (hs_count >= 4) ok = 1;
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (hs_count != 4) begin errors++; $display("FAIL fill_count: got %0d requests expected 4", hs_count); end
    checks++;
    if (hs_log.size() < 4 || hs_log[1] !== 64'h1004 || hs_log[2] !== 64'h1008 || hs_log[3] !== 64'h100C) begin errors++; $display("FAIL fill_addrs: got %0d entries, last %h expected 1004 1008 100c", hs_log.size(), hs_log[hs_log.size()-1]); end
    checks++;
    if (bus.icache_req_valid !== 1'b0) begin errors++; $display("FAIL full_req_valid: got %b expected 0", bus.icache_req_valid); end
    checks++;
    if (bus.out_pc !== 64'h1000) begin errors++; $display("FAIL full_head: got %h expected 1000", bus.out_pc); end
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
    checks++;
    if (bus.out_pc !== 64'h1004) begin errors++; $display("FAIL ack_head: got %h expected 1004", bus.out_pc); end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (hs_count != 5 || hs_log[hs_log.size()-1] !== 64'h1010) begin errors++; $display("FAIL ack_one_req: got %0d reqs last %h expected 5 reqs last 1010", hs_count, hs_log[hs_log.size()-1]); end
    checks++;
    if (bus.icache_req_valid !== 1'b0) begin errors++; $display("FAIL refull_req_valid: got %b expected 0", bus.icache_req_valid); end
    bus.out_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 64'h1004 + 64'(4 * i);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_instr !== (exp_pc[31:0] ^ 32'hDEAD0000)) begin errors++; $display("FAIL drain_%0d: got v=%b pc=%h instr=%h expected pc=%h", i, bus.out_valid, bus.out_pc, bus.out_instr, exp_pc); end
      tick();
    end
    bus.out_ack = 1'b0;
  endtask

  task automatic test_redirect_wait();
    bit ok;
    int unsigned n;
    n = hs_count;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (hs_count > n) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL t3_wait_hs: got timeout expected request"); end
    n = hs_count;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 64'h2002;
    tick();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t3_flush: got out_valid=%b expected 0", bus.out_valid); end
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (hs_count > n) ok = 1;
    end
    checks++;
    if (!ok || hs_log[hs_log.size()-1] !== 64'h2000) begin errors++; $display("FAIL t3_req_addr: got %h expected 2000", hs_log[hs_log.size()-1]); end
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (bus.out_valid === 1'b1) ok = 1;
    end
    checks++;
    if (!ok || bus.out_pc !== 64'h2000 || bus.out_instr !== 32'hDEAD2000) begin errors++; $display("FAIL t3_first_out: got pc=%h instr=%h expected 2000 dead2000", bus.out_pc, bus.out_instr); end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_flush_cnt !== 32'd1) begin errors++; $display("FAIL t3_perf_flush: got %0d expected 1", perf_flush_cnt); end
`endif
  endtask

  task automatic test_redirect_with_resp();
    bit ok;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (bus.icache_resp_valid === 1'b1) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL t4_wait_resp: got timeout expected response"); end
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 64'h3000;
    tick();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t4_no_push: got out_valid=%b expected 0", bus.out_valid); end
    checks++;
    if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 64'h3000) begin errors++; $display("FAIL t4_req: got v=%b addr=%h expected v=1 addr=3000", bus.icache_req_valid, bus.icache_req_addr); end
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (bus.out_valid === 1'b1) ok = 1;
    end
    checks++;
    if (!ok || bus.out_pc !== 64'h3000 || bus.out_instr !== 32'hDEAD3000) begin errors++; $display("FAIL t4_first_out: got pc=%h instr=%h expected 3000 dead3000", bus.out_pc, bus.out_instr); end
  endtask

  task automatic test_req_stall();
    bit ok;
    int unsigned n;
    bus.icache_req_ready = 1'b0;
    bus.out_ack = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    n = hs_count;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 64'h4000;
    tick();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 64'h4000 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL t5_redirect_req: got v=%b addr=%h ov=%b expected 1 4000 0", bus.icache_req_valid, bus.icache_req_addr, bus.out_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 64'h4000) begin errors++; $display("FAIL t5_stable_%0d: got v=%b addr=%h expected 1 4000", i, bus.icache_req_valid, bus.icache_req_addr); end
    end
    checks++;
    if (hs_count != n) begin errors++; $display("FAIL t5_no_hs: got %0d expected %0d", hs_count, n); end
    bus.icache_req_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (hs_count != n + 1 || hs_log[hs_log.size()-1] !== 64'h4000) begin errors++; $display("FAIL t5_single_req: got %0d last %h expected %0d 4000", hs_count, hs_log[hs_log.size()-1], n + 1); end
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (bus.out_valid === 1'b1) ok = 1;
    end
    checks++;
    if (!ok || bus.out_pc !== 64'h4000) begin errors++; $display("FAIL t5_first_out: got pc=%h expected 4000", bus.out_pc); end
    bus.out_ack = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    int unsigned n;
    n = hs_count;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (hs_count > n) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL t6_wait_hs: got timeout expected request"); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.icache_req_valid !== 1'b0 || bus.icache_req_addr !== 64'h0) begin errors++; $display("FAIL t6_ignored: got ov=%b rv=%b addr=%h expected 0 0 0", bus.out_valid, bus.icache_req_valid, bus.icache_req_addr); end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_fetch_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin errors++; $display("FAIL t6_perf: got %0d %0d expected 0 0", perf_fetch_cnt, perf_flush_cnt); end
`endif
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t6_idle_out: got %b expected 0", bus.out_valid); end
    bus.start_flag = 1'b1;
    tick();
    bus.start_flag = 1'b0;
    checks++;
    if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 64'h1000) begin errors++; $display("FAIL t6_reset_pc: got v=%b addr=%h expected 1 1000", bus.icache_req_valid, bus.icache_req_addr); end
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_fill_and_ack();
    test_redirect_wait();
    test_redirect_with_resp();
    test_req_stall();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
